minibus_master_bridge: RTL and testbench

// Upstream master stage for Mini-Bus slaves (register arrays, RAM). Accepts one load/store at a time from a

---
 rtl/minibus_master_bridge.sv | 175 +++++++++++++++++
 tb/tb_minibus_master_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/minibus_master_bridge.sv
// Core-side load/store port to Mini-Bus master: one outstanding request, timeout on missing ack,
// lane extraction with sign/zero extension on loads, early rejection of illegal or misaligned requests.
module minibus_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req_valid,
   output logic                  cpu_req_ready,
   input  logic                  cpu_req_wen,
   input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
   input  logic [1:0]            cpu_req_width,
   input  logic                  cpu_req_signed,
   input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
   output logic                  cpu_resp_valid,
   output logic                  cpu_resp_err,
   output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
   output logic                  mb_wen,
   output logic                  mb_ren,
   output logic [ADDR_WIDTH-1:0] mb_addr,
   output logic [1:0]            mb_width,
   output logic [DATA_WIDTH-1:0] mb_wdata,
   input  logic                  mb_ack,
   input  logic                  mb_err,
   input  logic [DATA_WIDTH-1:0] mb_rdata
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            width_q, width_d;
   logic                  signed_q, signed_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  req_bad;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [DATA_WIDTH-1:0] load_v;

   always_comb begin
      req_bad = 1'b0;
      case (cpu_req_width)
         W_HALF:  req_bad = cpu_req_addr[0];
         W_WORD:  req_bad = (cpu_req_addr[1:0] != 2'b00);
         W_BYTE:  req_bad = 1'b0;
         default: req_bad = 1'b1;
      endcase
   end

   // Slaves return the whole aligned word; pick the lane addressed by the low address bits.
   always_comb begin
      byte_v = mb_rdata[7:0];
      case (addr_q[1:0])
         2'd1:    byte_v = mb_rdata[15:8];
         2'd2:    byte_v = mb_rdata[23:16];
         2'd3:    byte_v = mb_rdata[31:24];
         default: byte_v = mb_rdata[7:0];
      endcase
      half_v = addr_q[1] ? mb_rdata[31:16] : mb_rdata[15:0];
      case (width_q)
         W_BYTE:  load_v = {{(DATA_WIDTH-8){signed_q & byte_v[7]}}, byte_v};
         W_HALF:  load_v = {{(DATA_WIDTH-16){signed_q & half_v[15]}}, half_v};
         default: load_v = mb_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wen_d    = wen_q;
      addr_d   = addr_q;
      width_d  = width_q;
      signed_d = signed_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req_valid) begin
               wen_d    = cpu_req_wen;
               addr_d   = cpu_req_addr;
               width_d  = cpu_req_width;
               signed_d = cpu_req_signed;
               wdata_d  = cpu_req_wdata;
               if (req_bad) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = '0;
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            // An ack in the final timeout cycle still completes normally.
            if (mb_ack) begin
               err_d   = mb_err;
               rdata_d = (wen_q || mb_err) ? '0 : load_v;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wen_q    <= 1'b0;
         addr_q   <= '0;
         width_q  <= '0;
         signed_q <= 1'b0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wen_q    <= wen_d;
         addr_q   <= addr_d;
         width_q  <= width_d;
         signed_q <= signed_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   logic in_bus, in_resp;
   assign in_bus  = (state_q == S_BUS);
   assign in_resp = (state_q == S_RESP);

   assign cpu_req_ready  = (state_q == S_IDLE);
   assign cpu_resp_valid = in_resp;
   assign cpu_resp_err   = in_resp & err_q;
   assign cpu_resp_rdata = in_resp ? rdata_q : '0;

   assign mb_wen   = in_bus & wen_q;
   assign mb_ren   = in_bus & ~wen_q;
   assign mb_addr  = in_bus ? addr_q  : '0;
   assign mb_width = in_bus ? width_q : '0;
   assign mb_wdata = in_bus ? wdata_q : '0;

endmodule

// File: tb/tb_minibus_master_bridge.sv
// Scoreboard bench for minibus_master_bridge: stimulus pushes expected responses, a forked monitor
// compares bus-side activity and response pulses; a small slave model acks after a programmable delay.
module tb_minibus_master_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req_valid = 1'b0;
   logic        cpu_req_ready;
   logic        cpu_req_wen = 1'b0;
   logic [31:0] cpu_req_addr = '0;
   logic [1:0]  cpu_req_width = '0;
   logic        cpu_req_signed = 1'b0;
   logic [31:0] cpu_req_wdata = '0;
   logic        cpu_resp_valid;
   logic        cpu_resp_err;
   logic [31:0] cpu_resp_rdata;
   logic        mb_wen, mb_ren;
   logic [31:0] mb_addr;
   logic [1:0]  mb_width;
   logic [31:0] mb_wdata;
   logic        mb_ack;
   logic        mb_err;
   logic [31:0] mb_rdata;

   logic [31:0] slv_rdata = 32'h80FF1234;
   logic        slv_err = 1'b0;
   int unsigned slv_ack_at = 1;
   int unsigned slv_cnt;
   logic        slv_ack;

   minibus_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_wen(cpu_req_wen), .cpu_req_addr(cpu_req_addr),
      .cpu_req_width(cpu_req_width), .cpu_req_signed(cpu_req_signed),
      .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_err(cpu_resp_err),
      .cpu_resp_rdata(cpu_resp_rdata),
      .mb_wen(mb_wen), .mb_ren(mb_ren), .mb_addr(mb_addr), .mb_width(mb_width),
      .mb_wdata(mb_wdata), .mb_ack(mb_ack), .mb_err(mb_err), .mb_rdata(mb_rdata)
   );

   always #5 clk = ~clk;

   // Slave: counts sampled request cycles, acks in the cycle after the count reaches slv_ack_at (0 = never).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         slv_cnt <= 0;
         slv_ack <= 1'b0;
      end else if (!(mb_wen || mb_ren)) begin
         slv_cnt <= 0;
         slv_ack <= 1'b0;
      end else if (slv_ack) begin
         slv_ack <= 1'b0;
      end else begin
         slv_cnt <= slv_cnt + 1;
         slv_ack <= (slv_ack_at != 0) && (slv_cnt + 1 == slv_ack_at);
      end
   end
   assign mb_ack   = slv_ack;
   assign mb_err   = slv_err;
   assign mb_rdata = slv_rdata;

   typedef struct {
      int unsigned cyc;
      logic        err;
      logic [31:0] rdata;
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  width;
      logic [31:0] wdata;
      int unsigned bus;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic monitor();
      int unsigned bus_cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            bus_cnt = 0;
         end else begin
            if (mb_wen || mb_ren) begin
               bus_cnt++;
               if (sb.size() == 0) begin
                  chk("unexpected_bus", 32'(mb_wen || mb_ren), 32'd0);
               end else begin
                  chk("mb_wen", 32'(mb_wen), 32'(sb[0].wen));
                  chk("mb_ren", 32'(mb_ren), 32'(!sb[0].wen));
                  chk("mb_addr", mb_addr, sb[0].addr);
                  chk("mb_width", 32'(mb_width), 32'(sb[0].width));
                  chk("mb_wdata", mb_wdata, sb[0].wdata);
               end
            end
            if (cpu_resp_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_resp", 32'(cpu_resp_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("resp_err", 32'(cpu_resp_err), 32'(e.err));
                  chk("resp_rdata", cpu_resp_rdata, e.rdata);
                  chk("resp_cycle", cyc, e.cyc);
                  chk("bus_cycles", bus_cnt, e.bus);
               end
               bus_cnt = 0;
            end else begin
               chk("idle_resp_err", 32'(cpu_resp_err), 32'd0);
               chk("idle_resp_rdata", cpu_resp_rdata, 32'd0);
            end
         end
      end
   endtask

   task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] width,
                        input logic sgn, input logic [31:0] wdata, input logic err,
                        input logic [31:0] rdata, input int unsigned lat, input int unsigned bus);
      int unsigned n = 0;
      exp_t e;
      @(negedge clk);
      while (!cpu_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(cpu_req_ready), 32'd1);
      #1;
      e.cyc = cyc + lat; e.err = err; e.rdata = rdata; e.wen = wen;
      e.addr = addr; e.width = width; e.wdata = wdata; e.bus = bus;
      sb.push_back(e);
      cpu_req_valid = 1'b1; cpu_req_wen = wen; cpu_req_addr = addr;
      cpu_req_width = width; cpu_req_signed = sgn; cpu_req_wdata = wdata;
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", 32'(cpu_req_ready), 32'd1);
      chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
      chk("rst_mb_en", 32'({mb_wen, mb_ren}), 32'd0);
      chk("rst_mb_addr", mb_addr, 32'd0);
      rst = 1'b0;

      // Stores
      issue(1'b1, 32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 3, 2);
      issue(1'b1, 32'h3, 2'b00, 1'b0, 32'h000000A5, 1'b0, 32'h0, 3, 2);
      // Loads from 0x80FF1234
      issue(1'b0, 32'h7, 2'b00, 1'b1, 32'h0, 1'b0, 32'hFFFFFF80, 3, 2);
      issue(1'b0, 32'h4, 2'b00, 1'b0, 32'h0, 1'b0, 32'h00000034, 3, 2);
      issue(1'b0, 32'h5, 2'b00, 1'b1, 32'h0, 1'b0, 32'h00000012, 3, 2);
      issue(1'b0, 32'h6, 2'b01, 1'b1, 32'h0, 1'b0, 32'hFFFF80FF, 3, 2);
      issue(1'b0, 32'h2, 2'b01, 1'b0, 32'h0, 1'b0, 32'h000080FF, 3, 2);
      issue(1'b0, 32'h0, 2'b01, 1'b1, 32'h0, 1'b0, 32'h00001234, 3, 2);
      issue(1'b0, 32'h8, 2'b10, 1'b1, 32'h0, 1'b0, 32'h80FF1234, 3, 2);
      // Rejects never reach the bus
      issue(1'b0, 32'h2, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0);
      issue(1'b0, 32'h1, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 1, 0);
      issue(1'b1, 32'h0, 2'b11, 1'b0, 32'h1, 1'b1, 32'h0, 1, 0);
      issue(1'b0, 32'h4, 2'b11, 1'b1, 32'h0, 1'b1, 32'h0, 1, 0);
      drain();

      // Timeout, ack in the last BUS cycle, and ack arriving after the timeout
      slv_ack_at = 0;
      issue(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 17, 16);
      drain();
      slv_ack_at = 15;
      issue(1'b0, 32'h7, 2'b00, 1'b1, 32'h0, 1'b0, 32'hFFFFFF80, 17, 16);
      drain();
      slv_ack_at = 16;
      issue(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 17, 16);
      drain();

      // Slave error on a load
      slv_ack_at = 1;
      slv_err = 1'b1;
      issue(1'b0, 32'hC, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 3, 2);
      drain();
      slv_err = 1'b0;

      // Reset while in BUS: request abandoned, no response
      slv_ack_at = 0;
      issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 17, 16);
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_ren", 32'(mb_ren), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_ren", 32'(mb_ren), 32'd0);
      chk("async_rst_ready", 32'(cpu_req_ready), 32'd1);
      chk("async_rst_valid", 32'(cpu_resp_valid), 32'd0);
      sb.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      slv_ack_at = 1;
      issue(1'b0, 32'h6, 2'b01, 1'b0, 32'h0, 1'b0, 32'h000080FF, 3, 2);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
